// File: rtl/ld_st_buffer.sv
// In-order load/store buffer: holds dispatched memory ops, captures missing
// operands from the CDB, and issues at most one op per cycle from the head to DM.
module ld_st_buffer #(
  parameter int BUFFER_SIZE_BITS = 4,
  parameter int ROB_SIZE_BITS    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  input  logic                   alloc_is_store,
  input  logic [ROB_SIZE_BITS:0] alloc_ROBEN,
  input  logic [ROB_SIZE_BITS:0] alloc_ROBEN1,
  input  logic [31:0]            alloc_ROBEN1_VAL,
  input  logic [ROB_SIZE_BITS:0] alloc_ROBEN2,
  input  logic [31:0]            alloc_ROBEN2_VAL,
  input  logic [31:0]            alloc_Immediate,
  input  logic                   CDB_valid,
  input  logic [ROB_SIZE_BITS:0] CDB_ROBEN,
  input  logic [31:0]            CDB_Result,
  input  logic                   commit_valid,
  input  logic [ROB_SIZE_BITS:0] commit_ROBEN,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic                   Read_en,
  output logic                   Write_en,
  output logic [ROB_SIZE_BITS:0] ROBEN,
  output logic [31:0]            address,
  output logic [31:0]            data,
  output logic [31:0]            LdStB_MEMU_ROBEN1_VAL,
  output logic [31:0]            LdStB_MEMU_Immediate
);
  localparam int DEPTH = 1 << BUFFER_SIZE_BITS;
  localparam logic [BUFFER_SIZE_BITS:0]   CNT_FULL = (BUFFER_SIZE_BITS+1)'(DEPTH);
  localparam logic [BUFFER_SIZE_BITS:0]   CNT_ONE  = (BUFFER_SIZE_BITS+1)'(1);
  localparam logic [BUFFER_SIZE_BITS-1:0] PTR_ONE  = BUFFER_SIZE_BITS'(1);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0]            is_store_q, is_store_d;
  logic [DEPTH-1:0]            committed_q, committed_d;
  logic [ROB_SIZE_BITS:0]      roben_q [DEPTH];
  logic [ROB_SIZE_BITS:0]      roben_d [DEPTH];
  logic [ROB_SIZE_BITS:0]      q1_q [DEPTH];
  logic [ROB_SIZE_BITS:0]      q1_d [DEPTH];
  logic [ROB_SIZE_BITS:0]      q2_q [DEPTH];
  logic [ROB_SIZE_BITS:0]      q2_d [DEPTH];
  logic [31:0]                 v1_q [DEPTH];
  logic [31:0]                 v1_d [DEPTH];
  logic [31:0]                 v2_q [DEPTH];
  logic [31:0]                 v2_d [DEPTH];
  logic [31:0]                 imm_q [DEPTH];
  logic [31:0]                 imm_d [DEPTH];

  logic [BUFFER_SIZE_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [BUFFER_SIZE_BITS:0]   count_q, count_d;

  logic                        rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ROB_SIZE_BITS:0]      roben_out_q, roben_out_d;
  logic [31:0]                 addr_q, addr_d, data_q, data_d;
  logic [31:0]                 base_q, base_d, imm_out_q, imm_out_d;

  logic                        issue_ok, do_alloc;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // Head qualifies purely from registered entry state: CDB/commit updates
  // made this cycle are only visible to issue on the next edge.
  assign issue_ok = valid_q[head_q] && (q1_q[head_q] == '0) &&
                    (!is_store_q[head_q] || ((q2_q[head_q] == '0) && committed_q[head_q]));
  assign do_alloc = alloc_valid && !full;

  always_comb begin
    valid_d     = valid_q;
    is_store_d  = is_store_q;
    committed_d = committed_q;
    roben_d     = roben_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    imm_d       = imm_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    roben_out_d = '0;
    addr_d      = addr_q;
    data_d      = data_q;
    base_d      = base_q;
    imm_out_d   = imm_out_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && CDB_valid) begin
        if ((q1_q[i] != '0) && (q1_q[i] == CDB_ROBEN)) begin
          q1_d[i] = '0;
          v1_d[i] = CDB_Result;
        end
        if ((q2_q[i] != '0) && (q2_q[i] == CDB_ROBEN)) begin
          q2_d[i] = '0;
          v2_d[i] = CDB_Result;
        end
      end
      if (commit_valid && valid_q[i] && is_store_q[i] && (roben_q[i] == commit_ROBEN))
        committed_d[i] = 1'b1;
    end

    if (issue_ok) begin
      rd_en_d              = !is_store_q[head_q];
      wr_en_d              = is_store_q[head_q];
      roben_out_d          = roben_q[head_q];
      addr_d               = v1_q[head_q] + imm_q[head_q];
      data_d               = is_store_q[head_q] ? v2_q[head_q] : 32'd0;
      base_d               = v1_q[head_q];
      imm_out_d            = imm_q[head_q];
      valid_d[head_q]      = 1'b0;
      committed_d[head_q]  = 1'b0;
      head_d               = head_q + PTR_ONE;
    end

    // tail never aliases an issuing head: that would need a full buffer
    if (do_alloc) begin
      valid_d[tail_q]     = 1'b1;
      is_store_d[tail_q]  = alloc_is_store;
      committed_d[tail_q] = 1'b0;
      roben_d[tail_q]     = alloc_ROBEN;
      q1_d[tail_q]        = alloc_ROBEN1;
      v1_d[tail_q]        = alloc_ROBEN1_VAL;
      q2_d[tail_q]        = alloc_ROBEN2;
      v2_d[tail_q]        = alloc_ROBEN2_VAL;
      imm_d[tail_q]       = alloc_Immediate;
      if (CDB_valid && (alloc_ROBEN1 != '0) && (alloc_ROBEN1 == CDB_ROBEN)) begin
        q1_d[tail_q] = '0;
        v1_d[tail_q] = CDB_Result;
      end
      if (CDB_valid && (alloc_ROBEN2 != '0) && (alloc_ROBEN2 == CDB_ROBEN)) begin
        q2_d[tail_q] = '0;
        v2_d[tail_q] = CDB_Result;
      end
      tail_d = tail_q + PTR_ONE;
    end

    if (do_alloc && !issue_ok)
      count_d = count_q + CNT_ONE;
    else if (!do_alloc && issue_ok)
      count_d = count_q - CNT_ONE;

    if (flush) begin
      valid_d     = '0;
      committed_d = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      rd_en_d     = 1'b0;
      wr_en_d     = 1'b0;
      roben_out_d = '0;
      addr_d      = '0;
      data_d      = '0;
      base_d      = '0;
      imm_out_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      committed_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      roben_out_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      base_q      <= '0;
      imm_out_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      committed_q <= committed_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      roben_out_q <= roben_out_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      base_q      <= base_d;
      imm_out_q   <= imm_out_d;
    end
  end

  // Entry payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    is_store_q <= is_store_d;
    roben_q    <= roben_d;
    q1_q       <= q1_d;
    q2_q       <= q2_d;
    v1_q       <= v1_d;
    v2_q       <= v2_d;
    imm_q      <= imm_d;
  end

  assign Read_en               = rd_en_q;
  assign Write_en              = wr_en_q;
  assign ROBEN                 = roben_out_q;
  assign address               = addr_q;
  assign data                  = data_q;
  assign LdStB_MEMU_ROBEN1_VAL = base_q;
  assign LdStB_MEMU_Immediate  = imm_out_q;
endmodule

// File: tb/tb_ld_st_buffer.sv
// Testbench for ld_st_buffer: directed scenarios plus randomized traffic, with
// expected issues queued at allocation and matched by an output monitor.
module tb_ld_st_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_is_store;
  logic [4:0]  alloc_ROBEN, alloc_ROBEN1, alloc_ROBEN2;
  logic [31:0] alloc_ROBEN1_VAL, alloc_ROBEN2_VAL, alloc_Immediate;
  logic        CDB_valid;
  logic [4:0]  CDB_ROBEN;
  logic [31:0] CDB_Result;
  logic        commit_valid;
  logic [4:0]  commit_ROBEN;
  logic        flush;
  logic        full, empty, Read_en, Write_en;
  logic [4:0]  ROBEN;
  logic [31:0] address, data, LdStB_MEMU_ROBEN1_VAL, LdStB_MEMU_Immediate;

  always #5 clk = ~clk;

  ld_st_buffer #(.BUFFER_SIZE_BITS(4), .ROB_SIZE_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store), .alloc_ROBEN(alloc_ROBEN),
    .alloc_ROBEN1(alloc_ROBEN1), .alloc_ROBEN1_VAL(alloc_ROBEN1_VAL),
    .alloc_ROBEN2(alloc_ROBEN2), .alloc_ROBEN2_VAL(alloc_ROBEN2_VAL),
    .alloc_Immediate(alloc_Immediate),
    .CDB_valid(CDB_valid), .CDB_ROBEN(CDB_ROBEN), .CDB_Result(CDB_Result),
    .commit_valid(commit_valid), .commit_ROBEN(commit_ROBEN), .flush(flush),
    .full(full), .empty(empty), .Read_en(Read_en), .Write_en(Write_en), .ROBEN(ROBEN),
    .address(address), .data(data),
    .LdStB_MEMU_ROBEN1_VAL(LdStB_MEMU_ROBEN1_VAL), .LdStB_MEMU_Immediate(LdStB_MEMU_Immediate)
  );

  typedef struct {
    bit          st;
    logic [4:0]  rob;
    logic [31:0] addr, data, base, imm;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, failures = 0;
  int          issued = 0, occ = 0;
  int          pending[$];
  int          uncommitted[$];
  logic [31:0] pval [32];
  int          next_rob = 1, next_tag = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every issue must match the oldest outstanding expected op.
  exp_t e_mon;
  always @(posedge clk) begin
    #1;
    if (Read_en === 1'b1 || Write_en === 1'b1) begin
      issued++;
      occ--;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue actual_ROBEN=%0d required=no_issue", ROBEN);
      end else begin
        e_mon = exp_q.pop_front();
        chk("sb_write_en", {31'd0, Write_en}, {31'd0, e_mon.st});
        chk("sb_read_en", {31'd0, Read_en}, {31'd0, !e_mon.st});
        chk("sb_roben", {27'd0, ROBEN}, {27'd0, e_mon.rob});
        chk("sb_address", address, e_mon.addr);
        chk("sb_data", data, e_mon.data);
        chk("sb_base", LdStB_MEMU_ROBEN1_VAL, e_mon.base);
        chk("sb_imm", LdStB_MEMU_Immediate, e_mon.imm);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_is_store = 0; alloc_ROBEN = 0;
    alloc_ROBEN1 = 0; alloc_ROBEN1_VAL = 0; alloc_ROBEN2 = 0; alloc_ROBEN2_VAL = 0;
    alloc_Immediate = 0; CDB_valid = 0; CDB_ROBEN = 0; CDB_Result = 0;
    commit_valid = 0; commit_ROBEN = 0; flush = 0;
  endtask

  // Directed alloc: store data is always ready; base_final is the value the base will hold.
  task automatic put(input bit st, input int rob, input int t1, input logic [31:0] v1,
                     input logic [31:0] dval, input logic [31:0] imm,
                     input logic [31:0] base_final, input bit push);
    exp_t e;
    alloc_valid = 1; alloc_is_store = st; alloc_ROBEN = 5'(rob);
    alloc_ROBEN1 = 5'(t1); alloc_ROBEN1_VAL = v1;
    alloc_ROBEN2 = 0; alloc_ROBEN2_VAL = dval; alloc_Immediate = imm;
    if (push) begin
      e.st = st; e.rob = 5'(rob); e.base = base_final; e.imm = imm;
      e.addr = base_final + imm; e.data = st ? dval : 32'd0;
      exp_q.push_back(e);
    end
  endtask

  function automatic bit in_pending(int t);
    foreach (pending[k]) if (pending[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int fresh_tag();
    int t;
    t = next_tag;
    while (in_pending(t)) t = t % 31 + 1;
    next_tag = t % 31 + 1;
    return t;
  endfunction

  task automatic pick_operand(output logic [4:0] tag, output logic [31:0] val,
                              output logic [31:0] final_val);
    int r;
    int t;
    r = $urandom_range(0, 2);
    val = $urandom;
    if (r == 0) begin
      tag = 0;
      final_val = val;
    end else if (r == 1 || pending.size() == 0 || pending.size() < 2) begin
      t = fresh_tag();
      pval[t] = $urandom;
      pending.push_back(t);
      tag = 5'(t);
      final_val = pval[t];
    end else begin
      t = pending[$urandom_range(0, pending.size() - 1)];
      tag = 5'(t);
      final_val = pval[t];
    end
  endtask

  task automatic alloc_random();
    exp_t e;
    logic [4:0]  t;
    logic [31:0] v, f;
    e.st = 1'($urandom_range(0, 1));
    e.rob = 5'(next_rob);
    next_rob = next_rob % 31 + 1;
    pick_operand(t, v, f);
    alloc_ROBEN1 = t; alloc_ROBEN1_VAL = v; e.base = f;
    e.imm = $urandom;
    alloc_Immediate = e.imm;
    e.addr = f + e.imm;
    if (e.st) begin
      pick_operand(t, v, f);
      alloc_ROBEN2 = t; alloc_ROBEN2_VAL = v; e.data = f;
      uncommitted.push_back(int'(e.rob));
    end else begin
      alloc_ROBEN2 = 5'($urandom); alloc_ROBEN2_VAL = $urandom; e.data = 0;
    end
    alloc_valid = 1; alloc_is_store = e.st; alloc_ROBEN = e.rob;
    exp_q.push_back(e);
    occ++;
  endtask

  task automatic retire_tag(input int t);
    foreach (pending[k]) if (pending[k] == t) begin
      pending.delete(k);
      return;
    end
  endtask

  int bc, guard, base_issued;

  initial begin
    idle();
    rst = 1;
    step(); step();
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_read_en", {31'd0, Read_en}, 0);
    chk("rst_write_en", {31'd0, Write_en}, 0);
    chk("rst_roben", {27'd0, ROBEN}, 0);
    chk("rst_address", address, 0);
    chk("rst_data", data, 0);
    rst = 0;

    // ready load: issues on the second edge after alloc
    put(0, 3, 0, 100, 0, 4, 100, 1);
    step(); idle();
    chk("t1_no_early_issue", {31'd0, Read_en}, 0);
    chk("t1_not_empty", {31'd0, empty}, 0);
    step();
    chk("t1_read_en", {31'd0, Read_en}, 1);
    chk("t1_address", address, 104);
    chk("t1_data", data, 0);
    step();
    chk("t1_read_en_drop", {31'd0, Read_en}, 0);
    chk("t1_empty_after", {31'd0, empty}, 1);

    // load waiting on a CDB base
    put(0, 5, 2, 32'hdead, 0, 12, 40, 1);
    step(); idle();
    for (int i = 0; i < 2; i++) begin
      chk("t2_wait_cdb", {31'd0, Read_en}, 0);
      step();
    end
    CDB_valid = 1; CDB_ROBEN = 2; CDB_Result = 40;
    step(); idle();
    chk("t2_no_same_edge_issue", {31'd0, Read_en}, 0);
    step();
    chk("t2_read_en", {31'd0, Read_en}, 1);
    chk("t2_address", address, 52);
    step();

    // store waits for commit
    put(1, 6, 0, 8, 77, 0, 8, 1);
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      chk("t3_wait_commit", {31'd0, Write_en}, 0);
      step();
    end
    commit_valid = 1; commit_ROBEN = 6;
    step(); idle();
    chk("t3_no_same_edge_issue", {31'd0, Write_en}, 0);
    step();
    chk("t3_write_en", {31'd0, Write_en}, 1);
    chk("t3_address", address, 8);
    chk("t3_data", data, 77);
    chk("t3_roben", {27'd0, ROBEN}, 6);
    step();

    // younger ready load stays behind an uncommitted store
    put(1, 7, 0, 16, 9, 4, 16, 1);
    step();
    put(0, 8, 0, 200, 0, 0, 200, 1);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      chk("t4_load_blocked", {31'd0, Read_en}, 0);
      step();
    end
    commit_valid = 1; commit_ROBEN = 7;
    step(); idle();
    step();
    chk("t4_store_first", {31'd0, Write_en}, 1);
    step();
    chk("t4_load_next", {31'd0, Read_en}, 1);
    chk("t4_load_roben", {27'd0, ROBEN}, 8);
    step();

    // fill to 16, drop the 17th, drain through the wrap
    for (int i = 0; i < 16; i++) begin
      put(0, i + 1, 9, 0, 0, 32'(i * 4), 1000, 1);
      step();
    end
    idle();
    chk("t5_full", {31'd0, full}, 1);
    chk("t5_not_empty", {31'd0, empty}, 0);
    put(0, 17, 0, 5, 0, 0, 5, 0);
    step(); idle();
    chk("t5_still_full", {31'd0, full}, 1);
    base_issued = issued;
    CDB_valid = 1; CDB_ROBEN = 9; CDB_Result = 1000;
    step(); idle();
    for (int i = 0; i < 18; i++) step();
    chk("t5_empty", {31'd0, empty}, 1);
    chk("t5_full_clear", {31'd0, full}, 0);
    chk("t5_issued16", 32'(issued - base_issued), 16);

    // flush beats alloc, CDB and issue
    for (int i = 0; i < 3; i++) begin
      put(0, 21 + i, 10, 0, 0, 0, 0, 0);
      step();
    end
    idle();
    flush = 1;
    put(0, 24, 0, 3, 0, 0, 3, 0);
    CDB_valid = 1; CDB_ROBEN = 10; CDB_Result = 5;
    step(); idle();
    chk("t6_empty", {31'd0, empty}, 1);
    chk("t6_full", {31'd0, full}, 0);
    chk("t6_read_en", {31'd0, Read_en}, 0);
    chk("t6_write_en", {31'd0, Write_en}, 0);
    chk("t6_roben", {27'd0, ROBEN}, 0);
    chk("t6_address", address, 0);
    chk("t6_data", data, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_issue", {31'd0, Read_en | Write_en}, 0);
    end

    // randomized traffic
    occ = 0;
    for (int c = 0; c < 800; c++) begin
      chk("rnd_full", {31'd0, full}, {31'd0, occ == 16});
      chk("rnd_empty", {31'd0, empty}, {31'd0, occ == 0});
      idle();
      bc = 0;
      if (pending.size() > 0 && $urandom_range(0, 2) == 0) begin
        bc = pending[$urandom_range(0, pending.size() - 1)];
        CDB_valid = 1; CDB_ROBEN = 5'(bc); CDB_Result = pval[bc];
      end
      if (uncommitted.size() > 0 && $urandom_range(0, 2) == 0) begin
        commit_valid = 1; commit_ROBEN = 5'(uncommitted.pop_front());
      end
      if (occ < 16 && $urandom_range(0, 1) == 1) alloc_random();
      step();
      if (bc != 0) retire_tag(bc);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      idle();
      bc = 0;
      if (pending.size() > 0) begin
        bc = pending[0];
        CDB_valid = 1; CDB_ROBEN = 5'(bc); CDB_Result = pval[bc];
      end
      if (uncommitted.size() > 0) begin
        commit_valid = 1; commit_ROBEN = 5'(uncommitted.pop_front());
      end
      step();
      if (bc != 0) retire_tag(bc);
      guard++;
    end
    idle();
    step(); step();
    chk("drain_outstanding", 32'(exp_q.size()), 0);
    chk("drain_empty", {31'd0, empty}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ld_st_buffer.md
Name: ld_st_buffer

Overview:
- In-order load/store buffer that sits directly upstream of the data memory unit (DM).
- Holds memory ops dispatched from the decode/rename stage and captures missing base/store-data operands by snooping the CDB.
- Issues at most one op per cycle from the head to DM: Read_en/Write_en, 32-bit address, data, ROBEN, plus base value and immediate for DM's range check.
- Stores issue only after the ROB marks them committed; loads issue as soon as their base operand is ready.

Parameters:
BUFFER_SIZE_BITS, 4, log2 of entry count (16 entries)
ROB_SIZE_BITS, 4, ROB tag width is ROB_SIZE_BITS+1; tag 0 means "no producer / value ready"

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
alloc_valid  in  1  dispatch a new entry this cycle
alloc_is_store  in  1  1 = store (sw), 0 = load (lw)
alloc_ROBEN  in  ROB_SIZE_BITS+1  ROB tag of the op
alloc_ROBEN1  in  ROB_SIZE_BITS+1  producer tag of base register, 0 = ready
alloc_ROBEN1_VAL  in  32  base value, valid when alloc_ROBEN1==0
alloc_ROBEN2  in  ROB_SIZE_BITS+1  producer tag of store data, 0 = ready (ignored for loads)
alloc_ROBEN2_VAL  in  32  store data value
alloc_Immediate  in  32  sign-extended offset
CDB_valid  in  1  CDB broadcast valid
CDB_ROBEN  in  ROB_SIZE_BITS+1  broadcast tag
CDB_Result  in  32  broadcast value
commit_valid  in  1  ROB commits a store this cycle
commit_ROBEN  in  ROB_SIZE_BITS+1  tag of the committing store
flush  in  1  mispredict flush, synchronous
full  out  1  count == 2^BUFFER_SIZE_BITS
empty  out  1  count == 0
Read_en  out  1  load issued to DM
Write_en  out  1  store issued to DM
ROBEN  out  ROB_SIZE_BITS+1  tag of the issued op
address  out  32  base + immediate (full 32-bit, wraps mod 2^32)
data  out  32  store data (0 for loads)
LdStB_MEMU_ROBEN1_VAL  out  32  base value of the issued op
LdStB_MEMU_Immediate  out  32  immediate of the issued op

Behaviour:
- Circular buffer with head/tail pointers (BUFFER_SIZE_BITS wide, natural wrap) and count (BUFFER_SIZE_BITS+1 wide).
- Entry fields: valid, is_store, ROBEN, Q1/V1, Q2/V2, Imm, committed.
- Reset and flush:
  - Clear all valid bits, head=tail=count=0, committed=0.
  - All outputs go to 0, except empty=1.
  - Flush takes priority over alloc, issue, CDB and commit in the same cycle.
- Allocation:
  - If alloc_valid && !full, write the entry at tail and increment tail.
  - Alloc while full is silently dropped; upstream must stall on full.
  - full/empty are derived from the registered count.
  - Alloc-time CDB bypass: if CDB_valid and CDB_ROBEN equals a non-zero alloc_ROBEN1/alloc_ROBEN2, store CDB_Result as the value and tag 0.
- CDB snoop: every valid entry with Qx!=0 && Qx==CDB_ROBEN && CDB_valid takes Vx<=CDB_Result, Qx<=0.
- Commit: a valid store entry with ROBEN==commit_ROBEN sets committed<=1.
- Issue condition, evaluated on the head entry at posedge:
  - Load: Q1==0.
  - Store: Q1==0 && Q2==0 && committed.
- Issue response:
  - When the condition holds, drive Read_en=!is_store, Write_en=is_store, ROBEN, address=V1+Imm, data (V2 for stores, 0 for loads), base value and immediate.
  - Outputs are registered, valid the cycle after the head qualifies.
  - Invalidate the head entry and increment head.
  - Otherwise Read_en=Write_en=0 and ROBEN=0; address/data hold their last values.
- Operands updated by the CDB in cycle N make the head issuable at posedge N+1; no same-edge snoop-to-issue bypass.
- Simultaneous alloc and issue: count is unchanged, both pointers advance.
- Alloc into an empty buffer: the entry issues no earlier than the following edge (latency ≥2 cycles from alloc_valid to Read_en).
- Strict program order; no load bypasses an older store.
- Timing relationship with DM:
  - Outputs are held one full cycle so DM samples them on negedge.
  - DM's invalid-address check uses LdStB_MEMU_ROBEN1_VAL+LdStB_MEMU_Immediate at posedge. This block performs no range check.

Test Plan:
- Reset, then alloc load {ROBEN=3, ROBEN1=0, VAL=100, Imm=4} → two edges later Read_en=1, ROBEN=3, address=104, data=0; next cycle Read_en=0, empty=1.
- Alloc load {ROBEN=5, ROBEN1=2}; CDB {tag 2, 40} three cycles later → no issue before the CDB; Read_en=1 with address=40+Imm on the second edge after the CDB cycle.
- Alloc store {ROBEN=6, base ready 8, Imm=0, data 77} → no Write_en until commit_valid/commit_ROBEN=6; then Write_en=1, address=8, data=77, ROBEN=6.
- Alloc store (uncommitted) then load (ready) → load does not issue while the store is blocked; after commit, store issues, then the load on the next edge.
- 16 allocs with no issue → full=1; a 17th alloc is dropped (count stays 16); draining all 16 gives empty=1 and head wraps to 0.
- Buffer holding 3 entries, flush=1 together with alloc_valid and a CDB match → next cycle empty=1, count=0, Read_en=Write_en=0, new alloc discarded.
